// File: rtl/vaddsub_pipe.sv
// Two-stage SEW-segmented vector add/subtract with signed/unsigned saturation.
// Stage 1 forms byte-sliced sums and carries; stage 2 clamps, masks and holds the result.
module vaddsub_pipe #(
    parameter int VECTOR_WIDTH = 64,
    parameter int VECTOR_BYTE  = VECTOR_WIDTH / 8,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VECTOR_WIDTH-1:0] in_vec1,
    input  logic [VECTOR_WIDTH-1:0] in_vec2,
    input  logic [2:0]              in_op,
    input  logic [1:0]              in_sew,
    input  logic [VECTOR_BYTE-1:0]  byte_en,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VECTOR_WIDTH-1:0] out_vec,
    output logic [VECTOR_BYTE-1:0]  out_be,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_sat
);

    localparam int NB = VECTOR_BYTE;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_RSUB  = 3'b010,
        OP_SADDU = 3'b011,
        OP_SADD  = 3'b100,
        OP_SSUBU = 3'b101,
        OP_SSUB  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    // Low byte-index bits that address a byte within one element.
    function automatic logic [2:0] elem_mask(input logic [1:0] sew);
        case (sew)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic byte_lsb(input int idx, input logic [1:0] sew);
        logic [2:0] ib;
        ib = 3'(idx);
        return (ib & elem_mask(sew)) == 3'b000;
    endfunction

    function automatic logic byte_top(input int idx, input logic [1:0] sew);
        logic [2:0] ib;
        ib = 3'(idx);
        return (ib & elem_mask(sew)) == elem_mask(sew);
    endfunction

    // Handshake: a request moves on in_valid & in_ready, a result on out_valid & out_ready.
    // Each stage advances when it is empty or the stage after it advances, so
    // in_ready follows out_ready combinationally and a full pipe drains and refills
    // in the same cycle.
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic run_q;
    logic s1_adv, s2_adv;

    logic [VECTOR_WIDTH-1:0] s1_sum_q;
    logic [NB-1:0]           s1_cout_q, s1_ovf_q, s1_asgn_q, s1_be_q;
    op_e                     s1_op_q;
    logic [1:0]              s1_sew_q;
    logic [ADDR_WIDTH-1:0]   s1_addr_q;

    logic [VECTOR_WIDTH-1:0] out_vec_q, out_vec_d;
    logic [NB-1:0]           out_be_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic                    out_sat_q, out_sat_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && run_q;

    assign s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

    // ---------------- stage 1: segmented adder ----------------
    op_e                     op_in;
    logic [VECTOR_WIDTH-1:0] opa, opb;
    logic                    sub_cin;
    logic [VECTOR_WIDTH-1:0] sum_d;
    logic [NB-1:0]           cout_d, ovf_d, asgn_d;

    assign op_in = op_e'(in_op);

    always_comb begin
        opa     = in_vec1;
        opb     = in_vec2;
        sub_cin = 1'b0;
        case (op_in)
            OP_SUB, OP_SSUBU, OP_SSUB: begin
                opb     = ~in_vec2;
                sub_cin = 1'b1;
            end
            OP_RSUB: begin
                opa     = in_vec2;
                opb     = ~in_vec1;
                sub_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic       c;
        logic [8:0] s9;
        logic [7:0] a_b, b_b;
        sum_d  = '0;
        cout_d = '0;
        ovf_d  = '0;
        asgn_d = '0;
        c      = sub_cin;
        s9     = '0;
        a_b    = '0;
        b_b    = '0;
        for (int i = 0; i < NB; i++) begin
            // The chain restarts at every element boundary with the op's carry-in.
            if (byte_lsb(i, in_sew)) c = sub_cin;
            a_b = opa[8*i +: 8];
            b_b = opb[8*i +: 8];
            s9  = {1'b0, a_b} + {1'b0, b_b} + {8'd0, c};
            sum_d[8*i +: 8] = s9[7:0];
            cout_d[i] = s9[8];
            ovf_d[i]  = (a_b[7] == b_b[7]) && (s9[7] != a_b[7]);
            asgn_d[i] = a_b[7];
            c = s9[8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_cout_q  <= '0;
            s1_ovf_q   <= '0;
            s1_asgn_q  <= '0;
            s1_be_q    <= '0;
            s1_op_q    <= OP_ADD;
            s1_sew_q   <= 2'd0;
            s1_addr_q  <= '0;
        end else begin
            run_q      <= 1'b1;
            s1_valid_q <= s1_valid_d;
            if (in_valid && in_ready) begin
                s1_sum_q  <= sum_d;
                s1_cout_q <= cout_d;
                s1_ovf_q  <= ovf_d;
                s1_asgn_q <= asgn_d;
                s1_be_q   <= byte_en;
                s1_op_q   <= op_in;
                s1_sew_q  <= in_sew;
                s1_addr_q <= in_addr;
            end
        end
    end

    // ---------------- stage 2: clamp, mask, flag ----------------
    // Spread each element's top-byte carry/overflow/sign across all its bytes.
    logic [NB-1:0] e_cout, e_ovf, e_asgn;

    always_comb begin
        logic c_top, o_top, s_top;
        e_cout = '0;
        e_ovf  = '0;
        e_asgn = '0;
        c_top  = 1'b0;
        o_top  = 1'b0;
        s_top  = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (byte_top(i, s1_sew_q)) begin
                c_top = s1_cout_q[i];
                o_top = s1_ovf_q[i];
                s_top = s1_asgn_q[i];
            end
            e_cout[i] = c_top;
            e_ovf[i]  = o_top;
            e_asgn[i] = s_top;
        end
    end

    always_comb begin
        logic       esat;
        logic [7:0] sval, rb;
        out_vec_d = '0;
        out_sat_d = 1'b0;
        esat      = 1'b0;
        sval      = 8'h00;
        rb        = 8'h00;
        for (int i = 0; i < NB; i++) begin
            esat = 1'b0;
            sval = 8'h00;
            case (s1_op_q)
                OP_SADDU: begin
                    esat = e_cout[i];
                    sval = 8'hFF;
                end
                OP_SSUBU: esat = !e_cout[i];
                OP_SADD, OP_SSUB: begin
                    esat = e_ovf[i];
                    if (byte_top(i, s1_sew_q)) sval = e_asgn[i] ? 8'h80 : 8'h7F;
                    else                       sval = e_asgn[i] ? 8'h00 : 8'hFF;
                end
                default: ;
            endcase
            rb = esat ? sval : s1_sum_q[8*i +: 8];
            if (s1_be_q[i]) begin
                out_vec_d[8*i +: 8] = rb;
                // Count an element once, through its least-significant byte.
                if (esat && byte_lsb(i, s1_sew_q)) out_sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_be_q    <= '0;
            out_addr_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_adv && s1_valid_q) begin
                out_vec_q  <= out_vec_d;
                out_be_q   <= s1_be_q;
                out_addr_q <= s1_addr_q;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_be    = out_be_q;
    assign out_addr  = out_addr_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vaddsub_pipe.sv
// Bench for vaddsub_pipe: directed cases, backpressure, mid-flight reset and
// randomized traffic scored against an element-level arithmetic model.
module tb_vaddsub_pipe;

    localparam int VW = 64;
    localparam int VB = VW / 8;
    localparam int AW = 32;
    localparam int EW = VW + VB + AW + 1;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_sat;
    logic [VW-1:0] in_vec1, in_vec2, out_vec;
    logic [2:0]    in_op;
    logic [1:0]    in_sew;
    logic [VB-1:0] byte_en, out_be;
    logic [AW-1:0] in_addr, out_addr;

    vaddsub_pipe #(.VECTOR_WIDTH(VW), .VECTOR_BYTE(VB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vec1(in_vec1), .in_vec2(in_vec2), .in_op(in_op), .in_sew(in_sew),
        .byte_en(byte_en), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_be(out_be), .out_addr(out_addr), .out_sat(out_sat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [2:0]    op;
        logic [1:0]    sew;
        logic [VB-1:0] be;
        logic [AW-1:0] addr;
    } req_t;

    req_t          stim_q[$];
    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    int            n_tests = 0, n_fail = 0, cyc = 0, n_out = 0;
    int            valid_pct = 100;
    bit            lat_chk = 0, saw_block = 0, presenting = 0;
    logic [VW-1:0] last_vec;
    logic          last_sat;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input req_t r);
        logic [VW-1:0]      res;
        logic               sat;
        int                 w, ne;
        logic signed [67:0] mask, smax, smin, ua, ub, sa, sb, rr;
        logic [63:0]        ev;
        w    = 8 << r.sew;
        ne   = VW / w;
        res  = '0;
        sat  = 1'b0;
        mask = (68'sd1 <<< w) - 68'sd1;
        smax = (68'sd1 <<< (w - 1)) - 68'sd1;
        smin = -(68'sd1 <<< (w - 1));
        for (int e = 0; e < ne; e++) begin
            logic esat;
            esat = 1'b0;
            ev = 64'(r.a >> (e * w));
            ua = $signed({4'b0, ev}) & mask;
            ev = 64'(r.b >> (e * w));
            ub = $signed({4'b0, ev}) & mask;
            sa = ua[w-1] ? ua - mask - 68'sd1 : ua;
            sb = ub[w-1] ? ub - mask - 68'sd1 : ub;
            case (r.op)
                3'd1: rr = ua - ub;
                3'd2: rr = ub - ua;
                3'd3: begin
                    rr = ua + ub;
                    if (rr > mask) begin rr = mask; esat = 1'b1; end
                end
                3'd4: begin
                    rr = sa + sb;
                    if (rr > smax)      begin rr = smax; esat = 1'b1; end
                    else if (rr < smin) begin rr = smin; esat = 1'b1; end
                end
                3'd5: begin
                    rr = ua - ub;
                    if (rr < 0) begin rr = 0; esat = 1'b1; end
                end
                3'd6: begin
                    rr = sa - sb;
                    if (rr > smax)      begin rr = smax; esat = 1'b1; end
                    else if (rr < smin) begin rr = smin; esat = 1'b1; end
                end
                default: rr = ua + ub;
            endcase
            res = res | (VW'(64'(rr & mask)) << (e * w));
            if (esat && r.be[(e * w) / 8]) sat = 1'b1;
        end
        for (int i = 0; i < VB; i++)
            if (!r.be[i]) res[8*i +: 8] = 8'h00;
        return {res, r.be, r.addr, sat};
    endfunction

    // ---------------- driver / scoreboard ----------------
    task automatic cycle(input bit rdy);
        req_t          r;
        logic [EW-1:0] e;
        int            ac;
        @(negedge clk);
        out_ready = rdy;
        if (stim_q.size() != 0 && (presenting || $urandom_range(99) < valid_pct)) begin
            r          = stim_q[0];
            presenting = 1'b1;
            in_valid   = 1'b1;
            in_vec1    = r.a;
            in_vec2    = r.b;
            in_op      = r.op;
            in_sew     = r.sew;
            byte_en    = r.be;
            in_addr    = r.addr;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        cyc++;
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (out_valid && out_ready) begin
            n_out++;
            last_vec = out_vec;
            last_sat = out_sat;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_cyc_q.pop_front();
                chk("out_vec", out_vec, e[EW-1 -: VW]);
                chk("out_be", out_be, e[AW+1 +: VB]);
                chk("out_addr", out_addr, e[AW:1]);
                chk("out_sat", out_sat, e[0]);
                if (lat_chk) chk("latency", cyc - ac, 2);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(stim_q[0]));
            acc_cyc_q.push_back(cyc);
            void'(stim_q.pop_front());
            presenting = 1'b0;
        end
    endtask

    task automatic drain(input bit rand_rdy, input int max_cyc);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
            cycle(rand_rdy ? ($urandom_range(99) < 65) : 1'b1);
            n++;
        end
        chk("drain_done", stim_q.size() + exp_q.size(), 0);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic req_t rand_req(input logic [AW-1:0] addr);
        req_t r;
        for (int i = 0; i < VB; i++) begin
            r.a[8*i +: 8] = rand_byte();
            r.b[8*i +: 8] = rand_byte();
        end
        r.op  = 3'($urandom_range(7));
        r.sew = 2'($urandom_range(3));
        case ($urandom_range(5))
            0:       r.be = VB'($urandom);
            1:       r.be = '0;
            default: r.be = '1;
        endcase
        r.addr = addr;
        return r;
    endfunction

    task automatic directed(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input logic [2:0] op, input logic [1:0] sew, input logic [VB-1:0] be,
                            input logic [VW-1:0] exp_vec, input logic exp_sat);
        req_t r;
        r.a = a; r.b = b; r.op = op; r.sew = sew; r.be = be;
        r.addr = AW'($urandom);
        stim_q.push_back(r);
        drain(1'b0, 50);
        chk({tag, "_vec"}, last_vec, exp_vec);
        chk({tag, "_sat"}, last_sat, exp_sat);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0, n0;
        req_t r;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_vec1 = '0; in_vec2 = '0; in_op = '0; in_sew = '0; byte_en = '0; in_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_out_be", out_be, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_sat", out_sat, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        lat_chk = 1'b1;
        valid_pct = 100;
        directed("t1_add8", 64'h00000000_000000FF, 64'h00000000_00000001, 3'b000, 2'b00, 8'hFF,
                 64'h0000000000000000, 1'b0);
        directed("t2_saddu16", 64'hFFFF_0001_7FFF_FFF0, 64'h0001_0001_0001_0020, 3'b011, 2'b01, 8'hFF,
                 64'hFFFF_0002_8000_FFFF, 1'b1);
        directed("t3_ssub32", 64'h80000000_00000005, 64'h00000001_00000007, 3'b110, 2'b10, 8'hFF,
                 64'h80000000_FFFFFFFE, 1'b1);
        directed("t3_ssub32_be", 64'h80000000_00000005, 64'h00000001_00000007, 3'b110, 2'b10, 8'h0F,
                 64'h00000000_FFFFFFFE, 1'b0);
        directed("t4_rsub64", 64'd5, 64'd3, 3'b010, 2'b11, 8'hFF, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        directed("ssubu_borrow", 64'h0003_0010_0000_0005, 64'h0004_0010_0001_0002, 3'b101, 2'b01, 8'hFF,
                 64'h0000_0000_0000_0003, 1'b1);

        // Full-rate stream: 50 beats should take 50 accepts plus 2 cycles of latency.
        c0 = cyc;
        for (int k = 0; k < 50; k++) stim_q.push_back(rand_req(AW'(32'h4000 + k)));
        drain(1'b0, 200);
        chk("throughput_cycles", cyc - c0, 52);
        lat_chk = 1'b0;

        // Backpressure: out_ready low on cycles 3..6 of a 6-beat stream.
        saw_block = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 6; k++) stim_q.push_back(rand_req(AW'(32'h100 + k)));
        for (int c = 1; c <= 12; c++) cycle(!(c >= 3 && c <= 6));
        drain(1'b0, 50);
        chk("t5_in_ready_drop", saw_block, 1'b1);
        chk("t5_beat_count", n_out - n0, 6);

        // Randomized traffic with random gaps and random backpressure.
        valid_pct = 70;
        for (int k = 0; k < 300; k++) stim_q.push_back(rand_req(AW'($urandom)));
        drain(1'b1, 5000);

        // Reset with two beats in flight.
        valid_pct = 100;
        for (int k = 0; k < 2; k++) stim_q.push_back(rand_req(AW'(32'h200 + k)));
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        chk("t6_valid_before_rst", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async_clear", out_valid, 1'b0);
        chk("t6_vec_async_clear", out_vec, 0);
        chk("t6_addr_async_clear", out_addr, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        stim_q.delete();
        presenting = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 8; c++) cycle(1'b1);
        chk("t6_no_stale_out", n_out - n0, 0);

        // Pipe still works after the mid-flight reset.
        r.a = 64'h7F; r.b = 64'h01; r.op = 3'b100; r.sew = 2'b00; r.be = 8'h01; r.addr = 32'h300;
        stim_q.push_back(r);
        drain(1'b0, 20);
        chk("post_rst_sadd_vec", last_vec, 64'h7F);
        chk("post_rst_sadd_sat", last_sat, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
